aes_flush_ctrl: RTL

// Front-end stage directly upstream of aes_top. Registers plain-text and key beats into the core,

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_inflight_cnt.sv | 39 +++
 rtl/aes_flush_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and widths for the AES front-end flush controller.
package aes_pkg;

    localparam int AES_DATA_W = 128;
    localparam int AES_KEY_L  = 128;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        QUIET,
        DONE,
        ERR
    } flush_state_e;

endpackage

// File: rtl/aes_inflight_cnt.sv
// Saturating up/down counter of blocks in the core pipeline, with an underflow event flag.
module aes_inflight_cnt #(
    parameter int MAX   = 32,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
        count_next = count;
        underflow  = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (count != MAX_CNT) count_next = count + 1'b1;
            end
            2'b01: begin
                if (count == '0) underflow = 1'b1;
                else             count_next = count - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) count <= '0;
        else          count <= count_next;
    end

endmodule

// File: rtl/aes_flush_ctrl.sv
// Front-end stage ahead of aes_top: registers data/key beats into the core, tracks in-flight
// blocks, and runs the flush handshake (quiesce, drain, quiet window, flush_done pulse).
module aes_flush_ctrl
    import aes_pkg::*;
#(
    parameter int DATA_W       = AES_DATA_W,
    parameter int KEY_L        = AES_KEY_L,
    parameter int MAX_INFLIGHT = 32,
    parameter int QUIET_CYCLES = 2,
    parameter int DRAIN_TMO    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_data_valid,
    input  logic [DATA_W-1:0] s_plain_text,
    input  logic              s_key_valid,
    input  logic [KEY_L-1:0]  s_cipher_key,
    output logic              s_ready,
    output logic              data_valid_in,
    output logic [DATA_W-1:0] plain_text,
    output logic              cipherkey_valid_in,
    output logic [KEY_L-1:0]  cipher_key,
    input  logic              core_valid_out,
    input  logic              flush_req,
    output logic              flush,
    output logic              flush_done,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int TMO_W = $clog2(DRAIN_TMO + 1);
    localparam int QC_W  = $clog2(QUIET_CYCLES + 1);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TMO - 1);
    localparam logic [QC_W-1:0]  QC_LAST  = QC_W'(QUIET_CYCLES - 1);

    flush_state_e     state;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_next;
    logic             underflow;
    logic [TMO_W-1:0] tmo;
    logic [QC_W-1:0]  qcnt;

    logic base_ready;
    logic key_acc;
    logic data_acc;
    logic tmo_expire;

    // A key load must not overtake blocks already in the core, so it waits for an empty pipe.
    assign base_ready = (state == IDLE) && !flush_req && (inflight < MAX_CNT) && !err;
    assign s_ready    = base_ready && (!s_key_valid || (inflight == '0));
    assign key_acc    = s_key_valid && s_ready;
    assign data_acc   = s_data_valid && !s_key_valid && s_ready;

    // Drain is judged on the post-edge count so QUIET starts right after the last result.
    assign tmo_expire = (state == DRAIN) && (inflight_next != '0) && (tmo == TMO_LAST);

    aes_inflight_cnt #(
        .MAX   (MAX_INFLIGHT),
        .CNT_W (CNT_W)
    ) u_inflight_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (data_acc),
        .dec        (core_valid_out),
        .count      (inflight),
        .count_next (inflight_next),
        .underflow  (underflow)
    );

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, because the core must see all-zero inputs out of reset.
        if (!reset_n) begin
            data_valid_in      <= 1'b0;
            cipherkey_valid_in <= 1'b0;
            plain_text         <= '0;
            cipher_key         <= '0;
        end else begin
            data_valid_in      <= data_acc;
            cipherkey_valid_in <= key_acc;
            if (data_acc) plain_text <= s_plain_text;
            if (key_acc)  cipher_key <= s_cipher_key;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) err <= 1'b0;
        else if (underflow || tmo_expire) err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            tmo        <= '0;
            qcnt       <= '0;
            flush      <= 1'b0;
            flush_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= DRAIN;
                        tmo   <= '0;
                        flush <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (inflight_next == '0) begin
                        state <= QUIET;
                        tmo   <= '0;
                        qcnt  <= '0;
                    end else if (tmo_expire) begin
                        state <= ERR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                QUIET: begin
                    if (core_valid_out) begin
                        qcnt <= '0;
                    end else if (qcnt == QC_LAST) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end else begin
                        qcnt <= qcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!flush_req) begin
                        state <= IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                ERR: begin
                    flush <= 1'b1;
                    busy  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
